// File: rtl/gated_clock_pkg.sv
// Shared types and default widths for the gated clock sequencer.
package gated_clock_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int RPT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Default-width sequence configuration: on/off phase lengths and period count
  typedef struct packed {
    logic [CNT_W_DEF-1:0] on;
    logic [CNT_W_DEF-1:0] off;
    logic [RPT_W_DEF-1:0] rpt;
  } cfg_t;

endpackage

// File: rtl/gated_clock_phase_cnt.sv
// Loadable down-counter with terminal-count flag; shared by the ON and OFF phases.
module gated_clock_phase_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - ONE;
    end
  end

  assign tc = (count_reg == '0);

endmodule

// File: rtl/gated_clock_seq.sv
// Gated clock enable sequencer: repeats on/off periods, stoppable early.
// Optional GATED_CLOCK_SEQ_CYC_CNT_EN adds a saturating en_cycles statistics counter.
module gated_clock_seq
  import gated_clock_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int RPT_W = RPT_W_DEF
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] on_cycles,
  input  logic [CNT_W-1:0] off_cycles,
  input  logic [RPT_W-1:0] num_repeat,
  output logic             clk_en,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
`ifdef GATED_CLOCK_SEQ_CYC_CNT_EN
  ,
  output logic [31:0]      en_cycles
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [RPT_W-1:0] RPT_ONE = {{(RPT_W-1){1'b0}}, 1'b1};

  // Same shape as cfg_t, sized by this instance's parameters
  typedef struct packed {
    logic [CNT_W-1:0] on;
    logic [CNT_W-1:0] off;
    logic [RPT_W-1:0] rpt;
  } cfg_w_t;

  state_t           state_reg;
  cfg_w_t           cfg_reg;
  logic [RPT_W-1:0] rpt_reg;
  logic             clk_en_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             cfg_err_reg;

  logic             accept;
  logic             active;
  logic             on_end;
  logic             period_end;
  logic             finish;
  logic [RPT_W-1:0] rpt_inc;
  logic             ph_load;
  logic [CNT_W-1:0] ph_val;
  logic             ph_tc;

  always_comb begin
    accept     = (state_reg == IDLE) && start && (on_cycles != '0);
    active     = (state_reg == ON) || (state_reg == OFF);
    on_end     = (state_reg == ON) && ph_tc;
    period_end = (on_end && (cfg_reg.off == '0)) || ((state_reg == OFF) && ph_tc);
    rpt_inc    = rpt_reg + RPT_ONE;
    finish     = period_end && (cfg_reg.rpt != '0) && (rpt_inc == cfg_reg.rpt);
    ph_load    = 1'b0;
    ph_val     = '0;
    if (accept) begin
      ph_load = 1'b1;
      ph_val  = on_cycles - CNT_ONE;
    end else if (active && !stop) begin
      if (on_end && (cfg_reg.off != '0)) begin
        ph_load = 1'b1;
        ph_val  = cfg_reg.off - CNT_ONE;
      end else if (period_end && !finish) begin
        ph_load = 1'b1;
        ph_val  = cfg_reg.on - CNT_ONE;
      end
    end
  end

  gated_clock_phase_cnt #(
    .W(CNT_W)
  ) u_phase_cnt (
    .clk      (ACLK),
    .rst      (ARESET),
    .load     (ph_load),
    .load_val (ph_val),
    .dec      (active),
    .tc       (ph_tc)
  );

  // Outputs are registered alongside the state so the gate buffer sees clean levels
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg   <= IDLE;
      cfg_reg     <= '0;
      rpt_reg     <= '0;
      clk_en_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      cfg_err_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (on_cycles != '0) begin
              cfg_reg     <= '{on: on_cycles, off: off_cycles, rpt: num_repeat};
              rpt_reg     <= '0;
              cfg_err_reg <= 1'b0;
              state_reg   <= ON;
              clk_en_reg  <= 1'b1;
              busy_reg    <= 1'b1;
            end else begin
              cfg_err_reg <= 1'b1;
            end
          end
        end
        ON, OFF: begin
          if (start) begin
            cfg_err_reg <= 1'b1;
          end
          if (stop || finish) begin
            state_reg  <= DONE;
            clk_en_reg <= 1'b0;
            done_reg   <= 1'b1;
          end else if (on_end && (cfg_reg.off != '0)) begin
            state_reg  <= OFF;
            clk_en_reg <= 1'b0;
          end else if (period_end) begin
            // With repeat==0 the period count simply wraps
            state_reg  <= ON;
            clk_en_reg <= 1'b1;
            rpt_reg    <= rpt_inc;
          end
        end
        DONE: begin
          if (start) begin
            cfg_err_reg <= 1'b1;
          end
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg  <= IDLE;
          clk_en_reg <= 1'b0;
          busy_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign clk_en  = clk_en_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign cfg_err = cfg_err_reg;

`ifdef GATED_CLOCK_SEQ_CYC_CNT_EN
  logic [31:0] en_cycles_reg;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      en_cycles_reg <= '0;
    end else if (accept) begin
      en_cycles_reg <= '0;
    end else if (clk_en_reg && (en_cycles_reg != 32'hFFFF_FFFF)) begin
      en_cycles_reg <= en_cycles_reg + 32'd1;
    end
  end

  assign en_cycles = en_cycles_reg;
`endif

endmodule

// File: doc/gated_clock_seq.md
GATED_CLOCK_SEQ -- requirements
Module: gated_clock_seq

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, the width of the on/off cycle counters.
REQ-002 The block SHALL have parameter RPT_W, default 8, the width of the repeat counter.
REQ-003 The block SHALL have port ACLK, input, 1 bit: single clock for all logic.
REQ-004 The block SHALL have port ARESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle request to begin a gating sequence.
REQ-006 The block SHALL have port stop, input, 1 bit: one-cycle request to end the sequence early.
REQ-007 The block SHALL have port on_cycles, input, CNT_W bits: enabled-phase length in ACLK cycles.
REQ-008 The block SHALL have port off_cycles, input, CNT_W bits: gated-phase length in ACLK cycles.
REQ-009 The block SHALL have port repeat, input, RPT_W bits: number of on/off periods, where 0 means run until stop.
REQ-010 The block SHALL have port clk_en, output, 1 bit: registered enable that drives the clock-gate buffer.
REQ-011 The block SHALL have port busy, output, 1 bit: high while not IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse at sequence end.
REQ-013 The block SHALL have port cfg_err, output, 1 bit: sticky flag, cleared only by an accepted start.

Function
REQ-014 The FSM SHALL have the states IDLE, ON, OFF and DONE.
REQ-015 In IDLE, a start with on_cycles!=0 SHALL latch on_cycles, off_cycles and repeat, clear cfg_err, and go to ON.
- clk_en SHALL be high from the cycle after start is sampled.
REQ-016 In IDLE, a start with on_cycles==0 SHALL set cfg_err and SHALL leave the FSM in IDLE.
REQ-017 A start sampled outside IDLE SHALL be ignored and SHALL set cfg_err.
REQ-018 Changes on the config inputs after the start is accepted SHALL have no effect until the next accepted start.
REQ-019 ON SHALL hold clk_en=1 for exactly the latched on_cycles cycles, then go to OFF.
REQ-020 OFF SHALL hold clk_en=0 for exactly the latched off_cycles cycles.
REQ-021 If the latched off_cycles==0, OFF SHALL be skipped and clk_en SHALL stay high continuously across period boundaries.
REQ-022 At the end of each period, the period count SHALL increment.
- If repeat!=0 and the count equals repeat, the FSM SHALL go to DONE.
- Otherwise the FSM SHALL go to ON.
REQ-023 With repeat==0, the period count SHALL wrap at 2^RPT_W without terminating.
REQ-024 A stop in ON or OFF SHALL force clk_en=0 in the next cycle and go to DONE.
- A stop in IDLE or DONE SHALL be ignored.
REQ-025 A start and a stop in the same cycle in IDLE SHALL be treated as start only.
REQ-026 A start and a stop in the same cycle in ON or OFF SHALL be treated as stop, and cfg_err SHALL be set.
REQ-027 DONE SHALL last one cycle with done=1 and clk_en=0, then go to IDLE.
- A start in DONE SHALL be ignored and SHALL set cfg_err.
REQ-028 busy SHALL equal (state!=IDLE).
REQ-029 clk_en, busy and done SHALL be driven from flops only, so that they are glitch-free for the gate buffer.

Reset
REQ-030 While ARESET=1, the block SHALL hold state=IDLE, clk_en=0, busy=0, done=0 and cfg_err=0, with all counters at 0, asynchronously.
REQ-031 Reset mid-sequence SHALL drop clk_en immediately and SHALL NOT produce a done pulse.
REQ-032 Release of ARESET SHALL be synchronised externally, and the first start SHALL be accepted on the first clock edge after deassertion.

Configuration
REQ-033 The macro GATED_CLOCK_SEQ_CYC_CNT_EN SHALL control a statistics counter.
- Defined: the block SHALL add output en_cycles, 32 bits, counting the ACLK cycles with clk_en=1.
- en_cycles SHALL saturate at 0xFFFFFFFF, clear on an accepted start, and reset to 0.
- Undefined: the port and the counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-034 The shared package gated_clock_pkg SHALL hold:
- the state enum typedef;
- the CNT_W and RPT_W default constants;
- the cfg struct typedef {on, off, repeat}.
REQ-035 A sub-module gated_clock_phase_cnt SHALL implement a loadable down-counter with terminal-count output.
- It SHALL be instantiated once and reused for the ON and OFF phases.

Verification
REQ-036 The bench SHALL apply on=3, off=2, repeat=2 and start.
- clk_en pattern SHALL be 1,1,1,0,0,1,1,1,0,0.
- done SHALL pulse on the next cycle.
- busy SHALL be high for 11 cycles.
REQ-037 The bench SHALL apply on=4, off=0, repeat=3.
- clk_en SHALL be high for 12 consecutive cycles, followed by a done pulse.
REQ-038 The bench SHALL apply on=0 and start.
- cfg_err SHALL be 1, busy SHALL stay 0 and clk_en SHALL stay 0.
- A following start with on=1 SHALL clear cfg_err.
REQ-039 The bench SHALL apply repeat=0, on=2, off=2, then stop in the 2nd cycle of the 5th ON phase.
- clk_en SHALL be 0 on the next cycle.
- done SHALL pulse once.
REQ-040 The bench SHALL issue a start in cycle 1 of ON during a sequence with on=5, off=5, repeat=1.
- The start SHALL be ignored and cfg_err SHALL be 1.
- The sequence SHALL complete unchanged.
REQ-041 The bench SHALL assert ARESET during OFF.
- Outputs SHALL go to 0 immediately with no done pulse.
- With GATED_CLOCK_SEQ_CYC_CNT_EN defined, en_cycles SHALL be 0.
